// File: rtl/alu_defs.sv
// Shared encodings for the execute-stage issue controller: ALU opcodes,
// RV32I major opcodes and branch funct3 values, plus decoder select types.
package alu_defs;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {SEL0_RS1, SEL0_PC, SEL0_ZERO} sel_in0_e;
  typedef enum logic {SEL1_RS2, SEL1_IMM} sel_in1_e;

  // Signed and unsigned compares share LT/GE: the ALU op already picks signedness.
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_type_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32I decode into ALU opcode, operand selects, immediates,
// write enable and branch type; unsupported encodings collapse to a zero ADD.
module alu_op_decoder
  import alu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [3:0]      alu_op_o,
  output sel_in0_e        sel_in0_o,
  output sel_in1_e        sel_in1_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] imm_b_o,
  output logic [4:0]      rd_o,
  output logic            we_o,
  output br_type_e        br_type_o,
  output logic            illegal_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode  = instr_i[6:0];
  assign funct3  = instr_i[14:12];
  assign funct7  = instr_i[31:25];
  assign rd_o    = instr_i[11:7];
  assign imm_b_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));

  always_comb begin
    alu_op_o  = ALU_ADD;
    sel_in0_o = SEL0_ZERO;
    sel_in1_o = SEL1_IMM;
    imm_o     = '0;
    we_o      = 1'b0;
    br_type_o = BR_NONE;
    illegal_o = 1'b0;
    case (opcode)
      OPC_OP: begin
        sel_in0_o = SEL0_RS1;
        sel_in1_o = SEL1_RS2;
        we_o      = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  alu_op_o = ALU_ADD;
            3'b001:  alu_op_o = ALU_SLL;
            3'b010:  alu_op_o = ALU_SLT;
            3'b011:  alu_op_o = ALU_SLTU;
            3'b100:  alu_op_o = ALU_XOR;
            3'b101:  alu_op_o = ALU_SRL;
            3'b110:  alu_op_o = ALU_OR;
            default: alu_op_o = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_op_o = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_op_o = ALU_SRA;
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_OPIMM: begin
        sel_in0_o = SEL0_RS1;
        we_o      = 1'b1;
        imm_o     = XLEN'($signed(instr_i[31:20]));
        case (funct3)
          3'b000: alu_op_o = ALU_ADD;
          3'b010: alu_op_o = ALU_SLT;
          3'b011: alu_op_o = ALU_SLTU;
          3'b100: alu_op_o = ALU_XOR;
          3'b110: alu_op_o = ALU_OR;
          3'b111: alu_op_o = ALU_AND;
          3'b001: begin
            imm_o    = XLEN'(instr_i[24:20]);
            alu_op_o = ALU_SLL;
            if (funct7 != F7_BASE) illegal_o = 1'b1;
          end
          default: begin
            imm_o = XLEN'(instr_i[24:20]);
            if (funct7 == F7_BASE)     alu_op_o = ALU_SRL;
            else if (funct7 == F7_ALT) alu_op_o = ALU_SRA;
            else                       illegal_o = 1'b1;
          end
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        sel_in0_o = (opcode == OPC_AUIPC) ? SEL0_PC : SEL0_ZERO;
        imm_o     = XLEN'($signed({instr_i[31:12], 12'h000}));
        we_o      = 1'b1;
      end
      OPC_BRANCH: begin
        sel_in0_o = SEL0_RS1;
        sel_in1_o = SEL1_RS2;
        case (funct3)
          F3_BEQ:  begin alu_op_o = ALU_SUB;  br_type_o = BR_EQ; end
          F3_BNE:  begin alu_op_o = ALU_SUB;  br_type_o = BR_NE; end
          F3_BLT:  begin alu_op_o = ALU_SLT;  br_type_o = BR_LT; end
          F3_BGE:  begin alu_op_o = ALU_SLT;  br_type_o = BR_GE; end
          F3_BLTU: begin alu_op_o = ALU_SLTU; br_type_o = BR_LT; end
          F3_BGEU: begin alu_op_o = ALU_SLTU; br_type_o = BR_GE; end
          default: illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
    // Illegal records still flow downstream, but as a harmless 0 + 0 with no write.
    if (illegal_o) begin
      alu_op_o  = ALU_ADD;
      sel_in0_o = SEL0_ZERO;
      sel_in1_o = SEL1_IMM;
      imm_o     = '0;
      we_o      = 1'b0;
      br_type_o = BR_NONE;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: decodes into an issue register that drives the
// external ALU, then captures the ALU return and branch outcome for writeback.
module alu_issue_ctrl
  import alu_defs::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_in0,
  output logic [XLEN-1:0] alu_in1,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [XLEN-1:0] out_pc,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  output logic            illegal
);

  logic [3:0]      decOp;
  sel_in0_e        decSel0;
  sel_in1_e        decSel1;
  logic [XLEN-1:0] decImm, decImmB, in0Sel, in1Sel;
  logic [4:0]      decRd;
  logic            decWe, decIllegal;
  br_type_e        decBr;

  logic            aValid_q, aValid_d, bValid_q, bValid_d;
  logic [XLEN-1:0] aIn0_q, aIn1_q, aPc_q, aImmB_q;
  logic [3:0]      aOp_q;
  logic [4:0]      aRd_q, bRd_q;
  logic            aWe_q, aIllegal_q, bWe_q, bIllegal_q, bTaken_q;
  br_type_e        aBr_q;
  logic [XLEN-1:0] bResult_q, bPc_q, bTarget_q;
  logic            bFree, accept, aAdvance, takenNow;

  alu_op_decoder #(.XLEN(XLEN)) u_decoder (
    .instr_i   (instr),
    .alu_op_o  (decOp),
    .sel_in0_o (decSel0),
    .sel_in1_o (decSel1),
    .imm_o     (decImm),
    .imm_b_o   (decImmB),
    .rd_o      (decRd),
    .we_o      (decWe),
    .br_type_o (decBr),
    .illegal_o (decIllegal)
  );

  always_comb begin
    case (decSel0)
      SEL0_RS1: in0Sel = rs1_data;
      SEL0_PC:  in0Sel = pc;
      default:  in0Sel = '0;
    endcase
    in1Sel = (decSel1 == SEL1_RS2) ? rs2_data : decImm;
  end

  assign bFree    = !bValid_q || out_ready;
  assign in_ready = !aValid_q || bFree;
  assign accept   = in_valid && in_ready;
  assign aAdvance = aValid_q && bFree;

  always_comb begin
    aValid_d = aValid_q;
    if (accept)        aValid_d = 1'b1;
    else if (aAdvance) aValid_d = 1'b0;
    bValid_d = bValid_q;
    if (aAdvance)       bValid_d = 1'b1;
    else if (out_ready) bValid_d = 1'b0;
  end

  always_comb begin
    case (aBr_q)
      BR_EQ:   takenNow = alu_zero;
      BR_NE:   takenNow = !alu_zero;
      BR_LT:   takenNow = alu_result[0];
      BR_GE:   takenNow = !alu_result[0];
      default: takenNow = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aValid_q   <= 1'b0;
      aIn0_q     <= '0;
      aIn1_q     <= '0;
      aOp_q      <= ALU_ADD;
      aRd_q      <= '0;
      aWe_q      <= 1'b0;
      aBr_q      <= BR_NONE;
      aPc_q      <= '0;
      aImmB_q    <= '0;
      aIllegal_q <= 1'b0;
    end else begin
      aValid_q <= aValid_d;
      if (accept) begin
        aIn0_q     <= in0Sel;
        aIn1_q     <= in1Sel;
        aOp_q      <= decOp;
        aRd_q      <= decRd;
        aWe_q      <= decWe && (decRd != 5'd0);
        aBr_q      <= decBr;
        aPc_q      <= pc;
        aImmB_q    <= decImmB;
        aIllegal_q <= decIllegal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bValid_q   <= 1'b0;
      bResult_q  <= '0;
      bRd_q      <= '0;
      bWe_q      <= 1'b0;
      bPc_q      <= RESET_PC_TAG;
      bTaken_q   <= 1'b0;
      bTarget_q  <= '0;
      bIllegal_q <= 1'b0;
    end else begin
      bValid_q <= bValid_d;
      if (aAdvance) begin
        bResult_q  <= alu_result;
        bRd_q      <= aRd_q;
        bWe_q      <= aWe_q;
        bPc_q      <= aPc_q;
        bTaken_q   <= takenNow;
        bTarget_q  <= aPc_q + aImmB_q;
        bIllegal_q <= aIllegal_q;
      end
    end
  end

  assign alu_in0       = aIn0_q;
  assign alu_in1       = aIn1_q;
  assign alu_op        = aOp_q;
  assign out_valid     = bValid_q;
  assign out_result    = bResult_q;
  assign out_rd        = bRd_q;
  assign out_we        = bWe_q;
  assign out_pc        = bPc_q;
  assign branch_taken  = bTaken_q;
  assign branch_target = bTarget_q;
  assign illegal       = bIllegal_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage controller that sits on the driving side of the ALU.
- Accepts an RV32I instruction with its PC and register operands, decodes it to the ALU opcode encoding, and drives in0/in1/ALU_op into the existing ALU.
- Captures result/zero_flag into an output register and resolves branches.
- Two-stage valid/ready pipeline between the decode/regfile stage and writeback.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_TAG, 0, value of out_pc after reset.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  block can accept an instruction this cycle
- instr  input  32  instruction word
- pc  input  XLEN  instruction address
- rs1_data  input  XLEN  rs1 register value
- rs2_data  input  XLEN  rs2 register value
- alu_in0  output  XLEN  ALU operand 0
- alu_in1  output  XLEN  ALU operand 1
- alu_op  output  4  ALU operation
- alu_result  input  XLEN  ALU result (combinational return)
- alu_zero  input  1  ALU zero_flag
- out_valid  output  1  writeback record valid
- out_ready  input  1  downstream accepts record
- out_result  output  XLEN  captured ALU result
- out_rd  output  5  destination register
- out_we  output  1  register write enable
- out_pc  output  XLEN  PC of the record
- branch_taken  output  1  branch resolved taken
- branch_target  output  XLEN  pc + B-immediate
- illegal  output  1  unsupported encoding

Behaviour:
- ALU_op encoding: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLTU=0101, SLT=0110, SLL=0111, SRL=1000, SRA=1001.
- Stage A (issue register)
  - Captures decoded alu_in0, alu_in1, alu_op, rd, we, branch type, pc, imm_b and illegal on in_valid && in_ready.
  - alu_* outputs are driven directly from stage A registers.
- Stage B (result register)
  - Captures alu_result, alu_zero, and the resolved branch when A advances.
- Handshake
  - b_free = !b_valid || out_ready.
  - in_ready = !a_valid || b_free.
  - A advances into B when a_valid && b_free.
  - Accept-to-out_valid latency is 2 cycles. Sustained throughput is 1 per cycle.
  - Outputs hold stable while out_valid && !out_ready.
- Decode
  - OP (0110011): funct7 0000000 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3. funct7 0100000 with funct3 000 selects SUB; with funct3 101 selects SRA. Any other funct7 is illegal.
  - OP-IMM (0010011): in1 = sign-extended imm_i. Shifts use in1 = {27'b0, shamt}.
    - SLLI requires funct7=0000000.
    - SRLI/SRAI require funct7 0000000/0100000.
  - LUI: in0=0, in1=imm_u, ADD.
  - AUIPC: in0=pc, in1=imm_u, ADD.
  - BRANCH (1100011): in0=rs1, in1=rs2, out_we=0.
    - BEQ/BNE use SUB: taken = zero / !zero.
    - BLT/BGE use SLT: taken = result[0] / !result[0].
    - BLTU/BGEU use SLTU with the same rule.
    - funct3 010/011 are illegal.
  - Any other opcode is illegal.
- Illegal records: flow through with illegal=1, out_we=0, branch_taken=0, alu_op=ADD, operands 0.
- rd=0 forces out_we=0.
- branch_target = pc + sign-extended imm_b, modulo 2^XLEN.
- branch_taken is 0 for non-branches.
- Reset (asynchronous, any cycle including mid-transfer):
  - a_valid=b_valid=0, so out_valid=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - All data outputs are 0; out_pc = RESET_PC_TAG.
  - In-flight records are dropped.

Decomposition:
- Package alu_defs holds:
  - ALU_op localparams;
  - opcode constants OPC_OP, OPC_OPIMM, OPC_BRANCH, OPC_LUI, OPC_AUIPC;
  - branch funct3 constants.
- Sub-module alu_op_decoder: combinational instr → {alu_op, sel_in0, sel_in1, imm, we, br_type, illegal}.
- The ALU itself is instantiated next to this block at the execute top level.

Test Plan:
- ADD x3,x1,x2 with rs1=0x7FFFFFFF, rs2=1 → alu_op=0000 while in A; 2 cycles after accept: out_result=0x80000000, out_rd=3, out_we=1.
- SRAI x5,x4,4 with rs1=0xF0000000 → alu_in1=0x00000004, alu_op=1001, out_result=0xFF000000.
- BEQ pc=0x100, imm=-8, rs1=rs2=0x1234 → branch_taken=1, branch_target=0xF8, out_we=0. Same with BLTU rs1=0xFFFFFFFF, rs2=1 → taken=0.
- Backpressure: three back-to-back ADDs with out_ready=0 for 4 cycles → in_ready drops after two accepts. After out_ready=1, all three records emerge in order with no loss or duplication.
- Illegal: instr with funct7=0000001 (MUL) → illegal=1, out_we=0. Following ADD is unaffected.
- Reset asserted while both stages are valid → out_valid=0 immediately. After release, in_ready=1 and the next instruction completes in 2 cycles.
